reg_file_lq: RTL

- Parametrised successor to the 8-bit, 8-entry register file.
- Two combinational read ports and one synchronous ALU write port, as before.
- r0 is hardwired to 0 and r1 to 1; a dedicated-register tap is kept.
- Adds synchronous reset, a load-return write port backed by an in-order pending-load queue, and a per-register scoreboard that flags read-after-load hazards to the decode/stall logic.

---
 rtl/reg_file_lq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/reg_file_lq.sv
// Parametrised register file: two combinational read ports, ALU and load-return write ports,
// in-order pending-load queue and per-register read-after-load scoreboard. Optional: REG_BYPASS_EN.
module reg_file_lq #(
    parameter int DW       = 8,
    parameter int AW       = 3,
    parameter int DED_REG  = 2,
    parameter int LQ_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          ld_issue,
    input  logic [AW-1:0] ld_addr,
    input  logic          ld_rsp_valid,
    input  logic [DW-1:0] ld_rsp_data,
    input  logic [AW-1:0] rd_addrA,
    input  logic [AW-1:0] rd_addrB,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    output logic [DW-1:0] ded_out,
    output logic          hazard,
    output logic          lq_full,
    output logic          lq_empty,
    output logic          err
);

    localparam int DEPTH = 2 ** AW;
    localparam int PW    = $clog2(LQ_DEPTH);
    localparam int CW    = $clog2(LQ_DEPTH + 1);

    logic [DW-1:0] core_q   [DEPTH];
    logic [DW-1:0] core_d   [DEPTH];
    logic [CW-1:0] pend_q   [DEPTH];
    logic [CW-1:0] pend_d   [DEPTH];
    logic [AW-1:0] lqAddr_q [LQ_DEPTH];
    logic [AW-1:0] lqAddr_d [LQ_DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic          full, empty, rspFire, pushEn, overflow, underflow;
    logic          ldWrite, aluWrite;
    logic [AW-1:0] head;
    logic          maskA, maskB, busyA, busyB;

    function automatic logic isHw(input logic [AW-1:0] a);
        return 32'(a) < 32'd2;
    endfunction

    // Queue control: a response frees a slot, so a simultaneous issue is accepted even when full.
    always_comb begin
        full      = (count_q == CW'(LQ_DEPTH));
        empty     = (count_q == '0);
        head      = lqAddr_q[rdPtr_q];
        rspFire   = ld_rsp_valid && !empty;
        pushEn    = ld_issue && (!full || rspFire);
        overflow  = ld_issue && full && !rspFire;
        underflow = ld_rsp_valid && empty;
        ldWrite   = rspFire && !isHw(head);
        aluWrite  = wr_en && !isHw(wr_addr) && !(ldWrite && (wr_addr == head));
    end

    always_comb begin
        core_d   = core_q;
        pend_d   = pend_q;
        lqAddr_d = lqAddr_q;
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        err_d    = err_q | overflow | underflow;
        if (aluWrite) core_d[wr_addr] = wr_data;
        if (ldWrite)  core_d[head]    = ld_rsp_data;
        core_d[0] = '0;
        core_d[1] = DW'(1);
        if (pushEn) begin
            lqAddr_d[wrPtr_q] = ld_addr;
            wrPtr_d           = wrPtr_q + PW'(1);
        end
        if (rspFire) rdPtr_d = rdPtr_q + PW'(1);
        if (pushEn && !rspFire)      count_d = count_q + CW'(1);
        else if (rspFire && !pushEn) count_d = count_q - CW'(1);
        for (int i = 0; i < DEPTH; i++) begin
            if (pushEn && (ld_addr == AW'(i)) && !(rspFire && (head == AW'(i))))
                pend_d[i] = pend_q[i] + CW'(1);
            else if (rspFire && (head == AW'(i)) && !(pushEn && (ld_addr == AW'(i))))
                pend_d[i] = pend_q[i] - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                core_q[i] <= (i == 1) ? DW'(1) : '0;
                pend_q[i] <= '0;
            end
            for (int j = 0; j < LQ_DEPTH; j++) lqAddr_q[j] <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            core_q   <= core_d;
            pend_q   <= pend_d;
            lqAddr_q <= lqAddr_d;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Read ports; r0/r1 are decoded here so they never depend on stored state.
    always_comb begin
        datA_out = (rd_addrA == '0) ? '0 : isHw(rd_addrA) ? DW'(1) : core_q[rd_addrA];
        datB_out = (rd_addrB == '0) ? '0 : isHw(rd_addrB) ? DW'(1) : core_q[rd_addrB];
        maskA    = 1'b0;
        maskB    = 1'b0;
`ifdef REG_BYPASS_EN
        if (ldWrite && (head == rd_addrA)) begin
            datA_out = ld_rsp_data;
            maskA    = 1'b1;
        end else if (aluWrite && (wr_addr == rd_addrA)) begin
            datA_out = wr_data;
        end
        if (ldWrite && (head == rd_addrB)) begin
            datB_out = ld_rsp_data;
            maskB    = 1'b1;
        end else if (aluWrite && (wr_addr == rd_addrB)) begin
            datB_out = wr_data;
        end
`endif
        busyA  = (pend_q[rd_addrA] != '0) && !isHw(rd_addrA);
        busyB  = (pend_q[rd_addrB] != '0) && !isHw(rd_addrB);
        hazard = (busyA && !maskA) || (busyB && !maskB);
    end

    assign ded_out  = (DED_REG == 0) ? '0 : (DED_REG == 1) ? DW'(1) : core_q[DED_REG];
    assign lq_full  = full;
    assign lq_empty = empty;
    assign err      = err_q;

endmodule
